// File: rtl/wishbone_master_pkg.sv
// Shared constants for the Wishbone master: default bus widths and FSM state codes.
package wishbone_master_pkg;

    localparam int WB_ADDR_WIDTH = 2;
    localparam int WB_DATA_WIDTH = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

endpackage

// File: rtl/wishbone_master_wb_timeout_counter.sv
// Cycle counter bounding how long a Wishbone cycle may stay open.
module wb_timeout_counter
    import wishbone_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge i_clk) begin
        if (i_reset)       count <= '0;
        else if (i_clear)  count <= '0;
        else if (i_enable) count <= count + CNT_W'(1);
    end

    // Flags the last cycle the bus cycle may remain open.
    assign o_terminal = (count == LAST);

endmodule

// File: rtl/wishbone_master.sv
// Single-outstanding Wishbone pipelined-mode master: one bus cycle and one response per request.
module wishbone_master
    import wishbone_master_pkg::*;
#(
    parameter int ADDR_WIDTH     = WB_ADDR_WIDTH,
    parameter int DATA_WIDTH     = WB_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_data,
    output logic                  o_rsp_valid,
    output logic                  o_rsp_err,
    output logic [DATA_WIDTH-1:0] o_rsp_data,
    output logic                  o_wb_cyc,
    output logic                  o_wb_stb,
    output logic                  o_wb_we,
    output logic [ADDR_WIDTH-1:0] o_wb_addr,
    output logic [DATA_WIDTH-1:0] o_wb_odata,
    input  logic                  i_wb_ack,
    input  logic                  i_wb_stall,
    input  logic                  i_wb_err,
    input  logic [DATA_WIDTH-1:0] i_wb_idata
);

    logic [1:0] state;
    logic       accept;
    logic       busy;
    logic       strobe_taken;
    logic       bus_done;
    logic       timed_out;
    logic       abort;

    assign o_req_ready  = (state == ST_IDLE);
    assign accept       = i_req_valid && o_req_ready;
    assign busy         = (state == ST_REQ) || (state == ST_WAIT);
    assign strobe_taken = (state == ST_REQ) && !i_wb_stall;
    // A slave reply only counts once the strobe has been taken.
    assign bus_done     = ((state == ST_WAIT) || strobe_taken) && (i_wb_ack || i_wb_err);
    assign abort        = busy && !bus_done && timed_out;

    wb_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_clear    (accept),
        .i_enable   (busy),
        .o_terminal (timed_out)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= ST_IDLE;
            o_wb_cyc    <= 1'b0;
            o_wb_stb    <= 1'b0;
            o_wb_we     <= 1'b0;
            o_wb_addr   <= '0;
            o_wb_odata  <= '0;
            o_rsp_valid <= 1'b0;
            o_rsp_err   <= 1'b0;
            o_rsp_data  <= '0;
        end else begin
            o_rsp_valid <= 1'b0;
            if (bus_done || abort) begin
                // Error beats ack; errors and writes return zero data.
                state       <= ST_RESP;
                o_wb_cyc    <= 1'b0;
                o_wb_stb    <= 1'b0;
                o_rsp_valid <= 1'b1;
                o_rsp_err   <= abort || i_wb_err;
                o_rsp_data  <= (abort || i_wb_err || o_wb_we) ? '0 : i_wb_idata;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (accept) begin
                            state      <= ST_REQ;
                            o_wb_cyc   <= 1'b1;
                            o_wb_stb   <= 1'b1;
                            o_wb_we    <= i_req_we;
                            o_wb_addr  <= i_req_addr;
                            o_wb_odata <= i_req_data;
                        end
                    end
                    ST_REQ: begin
                        if (!i_wb_stall) begin
                            state    <= ST_WAIT;
                            o_wb_stb <= 1'b0;
                        end
                    end
                    ST_WAIT: state <= ST_WAIT;
                    ST_RESP: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef FORMAL
    logic f_pending;
    always_ff @(posedge i_clk) begin
        if (i_reset)          f_pending <= 1'b0;
        else if (accept)      f_pending <= 1'b1;
        else if (o_rsp_valid) f_pending <= 1'b0;
    end
    a_stb_cyc: assert property (@(posedge i_clk) disable iff (i_reset) o_wb_stb |-> o_wb_cyc);
    a_stable:  assert property (@(posedge i_clk) disable iff (i_reset)
                   (o_wb_stb && i_wb_stall) |=> $stable({o_wb_we, o_wb_addr, o_wb_odata}));
    a_one_rsp: assert property (@(posedge i_clk) disable iff (i_reset) o_rsp_valid |-> f_pending);
`endif

endmodule
